// File: rtl/mac_seq_ctrl.sv
// Operand sequencer feeding a signed MAC: streams pairs, drains the MAC pipeline,
// captures the dot-product into a handshaked output. Optional MACSEQ_TRUNC_FLAG_EN adds out_trunc.
module mac_seq_ctrl #(
   parameter int WIDTH   = 8,
   parameter int CNT_W   = 8,
   parameter int MAX_LEN = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic                 in_last,
   output logic                 mac_clr,
   output logic [WIDTH-1:0]     mac_a,
   output logic [WIDTH-1:0]     mac_b,
   input  logic [2*WIDTH-1:0]   mac_result,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_data,
   output logic [CNT_W-1:0]     out_count
`ifdef MACSEQ_TRUNC_FLAG_EN
   ,
   output logic                 out_trunc
`endif
);

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      DRAIN   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   r_len;
   logic [WIDTH-1:0]   r_mac_a;
   logic [WIDTH-1:0]   r_mac_b;
   logic               r_out_valid;
   logic [2*WIDTH-1:0] r_out_data;
   logic [CNT_W-1:0]   r_out_count;

   logic               w_fire_in;
   logic               w_end_vec;
   logic               w_cap_fire;
   logic [CNT_W-1:0]   w_cnt_inc;

   assign w_fire_in  = in_valid && in_ready;
   assign w_cnt_inc  = r_count + 1'b1;
   assign w_end_vec  = w_fire_in && (in_last || (w_cnt_inc == CNT_W'(MAX_LEN)));
   assign w_cap_fire = (r_state == CAPTURE) && (!r_out_valid || out_ready);

   assign in_ready  = (r_state == ACCUM) && !rst;
   // Clearing on rst keeps the MAC aligned with the sequencer after reset.
   assign mac_clr   = rst || w_cap_fire;
   assign mac_a     = r_mac_a;
   assign mac_b     = r_mac_b;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_count = r_out_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ACCUM:   if (w_end_vec) w_state_next = DRAIN;
         DRAIN:   w_state_next = CAPTURE;
         CAPTURE: if (w_cap_fire) w_state_next = ACCUM;
         default: w_state_next = ACCUM;
      endcase
   end

   // Idle cycles present 0*0 so the enable-less MAC holds its sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mac_a <= '0;
         r_mac_b <= '0;
      end else if (w_fire_in) begin
         r_mac_a <= in_a;
         r_mac_b <= in_b;
      end else begin
         r_mac_a <= '0;
         r_mac_b <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
         r_len   <= '0;
      end else if (w_end_vec) begin
         r_count <= '0;
         r_len   <= w_cnt_inc;
      end else if (w_fire_in) begin
         r_count <= w_cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_count <= '0;
      end else if (w_cap_fire) begin
         r_out_valid <= 1'b1;
         r_out_data  <= mac_result;
         r_out_count <= r_len;
      end else if (r_out_valid && out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

`ifdef MACSEQ_TRUNC_FLAG_EN
   logic r_trunc_pend;
   logic r_out_trunc;

   assign out_trunc = r_out_trunc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_trunc_pend <= 1'b0;
         r_out_trunc  <= 1'b0;
      end else begin
         if (w_end_vec) r_trunc_pend <= !in_last;
         if (w_cap_fire) r_out_trunc <= r_trunc_pend;
      end
   end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a behavioural signed MAC attached (MAX_LEN=4).
// Honours MACSEQ_TRUNC_FLAG_EN for the out_trunc checks.
module tb_mac_seq_ctrl;

   localparam int WIDTH   = 8;
   localparam int CNT_W   = 8;
   localparam int MAX_LEN = 4;

   logic                 clk;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_a;
   logic [WIDTH-1:0]     in_b;
   logic                 in_last;
   logic                 mac_clr;
   logic [WIDTH-1:0]     mac_a;
   logic [WIDTH-1:0]     mac_b;
   logic [2*WIDTH-1:0]   mac_result;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   out_data;
   logic [CNT_W-1:0]     out_count;
`ifdef MACSEQ_TRUNC_FLAG_EN
   logic                 out_trunc;
`endif

   int n_checks = 0;
   int n_errors = 0;

   mac_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_LEN(MAX_LEN)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_last    (in_last),
      .mac_clr    (mac_clr),
      .mac_a      (mac_a),
      .mac_b      (mac_b),
      .mac_result (mac_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_count  (out_count)
`ifdef MACSEQ_TRUNC_FLAG_EN
      ,
      .out_trunc  (out_trunc)
`endif
   );

   // Behavioural signed MAC: registered accumulator, synchronous clear.
   logic signed [2*WIDTH-1:0] mac_prod;
   assign mac_prod = $signed(mac_a) * $signed(mac_b);

   always @(posedge clk) begin
      if (mac_clr) mac_result <= '0;
      else         mac_result <= mac_result + mac_prod;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Drive a pair at a negedge, hold until accepted, return at the negedge after acceptance.
   task automatic put_pair(input logic [7:0] a, input logic [7:0] b, input logic last);
      int waited;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_last  = last;
      waited   = 0;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("mac_a_load", 32'(mac_a), 32'(a));
      check("mac_b_load", 32'(mac_b), 32'(b));
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_last  = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [15:0] exp_data,
                              input logic [7:0] exp_cnt, input logic exp_trunc);
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd2);
      check({tag, "_data"}, 32'(out_data), 32'(exp_data));
      check({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
`ifdef MACSEQ_TRUNC_FLAG_EN
      check({tag, "_trunc"}, 32'(out_trunc), 32'(exp_trunc));
`else
      if (exp_trunc) lat = lat; // no flag port in this build
`endif
   endtask

   initial begin
      rst       = 1'b1;
      out_ready = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_count", 32'(out_count), 32'd0);
      check("rst_mac_a", 32'(mac_a), 32'd0);
      check("rst_mac_clr", 32'(mac_clr), 32'd1);
      check("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef MACSEQ_TRUNC_FLAG_EN
      check("rst_out_trunc", 32'(out_trunc), 32'd0);
`endif
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      check("post_rst_mac_clr", 32'(mac_clr), 32'd0);

      // Two-pair vector: 3*4 + (-2)*5 = 2
      put_pair(8'd3, 8'd4, 1'b0);
      put_pair(8'hFE, 8'd5, 1'b1);
      idle();
      wait_result("two_pair", 16'h0002, 8'd2, 1'b0);
      @(negedge clk);
      check("two_pair_valid_drop", 32'(out_valid), 32'd0);
      check("two_pair_mac_cleared", 32'(mac_result), 32'd0);

      // Extreme single pair, then a fresh vector proves the clear
      put_pair(8'h80, 8'h80, 1'b1);
      idle();
      wait_result("extreme", 16'h4000, 8'd1, 1'b0);
      put_pair(8'd1, 8'd1, 1'b1);
      idle();
      wait_result("after_extreme", 16'h0001, 8'd1, 1'b0);

      // Back-pressure: A=6 held, B=25 stalls in CAPTURE
      @(negedge clk);
      out_ready = 1'b0;
      put_pair(8'd2, 8'd3, 1'b1);
      idle();
      wait_result("bp_a", 16'd6, 8'd1, 1'b0);
      put_pair(8'd5, 8'd5, 1'b1);
      idle();
      repeat (4) @(negedge clk);
      check("bp_stall_in_ready", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'd6);
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_b_valid", 32'(out_valid), 32'd1);
      check("bp_b_data", 32'(out_data), 32'd25);
      check("bp_b_count", 32'(out_count), 32'd1);
      @(negedge clk);
      check("bp_b_consumed", 32'(out_valid), 32'd0);

      // Forced end at MAX_LEN=4; fifth pair opens a new vector
      put_pair(8'd1, 8'd1, 1'b0);
      put_pair(8'd1, 8'd1, 1'b0);
      put_pair(8'd1, 8'd1, 1'b0);
      put_pair(8'd1, 8'd1, 1'b0);
      check("forced_in_ready_low", 32'(in_ready), 32'd0);
      idle();
      wait_result("forced", 16'd4, 8'd4, 1'b1);
      put_pair(8'd1, 8'd1, 1'b1);
      idle();
      wait_result("fifth", 16'd1, 8'd1, 1'b0);

      // Gaps between pairs add nothing: 7*2 + 1*(-1) = 13
      put_pair(8'd7, 8'd2, 1'b0);
      idle();
      repeat (3) @(negedge clk);
      check("gap_mac_idle_a", 32'(mac_a), 32'd0);
      put_pair(8'd1, 8'hFF, 1'b1);
      idle();
      wait_result("gaps", 16'd13, 8'd2, 1'b0);

      // Reset mid-vector with a pending result
      @(negedge clk);
      out_ready = 1'b0;
      put_pair(8'd2, 8'd2, 1'b1);
      idle();
      wait_result("pending", 16'd4, 8'd1, 1'b0);
      put_pair(8'd10, 8'd10, 1'b0);
      put_pair(8'd10, 8'd10, 1'b0);
      idle();
      rst = 1'b1;
      #1;
      check("midrst_mac_clr", 32'(mac_clr), 32'd1);
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_mac_result", 32'(mac_result), 32'd0);
      put_pair(8'd1, 8'd2, 1'b1);
      idle();
      wait_result("after_rst", 16'd2, 8'd1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Operand sequencer placed directly upstream of the signed MAC accumulator (WIDTH-bit signed a/b, 2*WIDTH-bit registered accumulator, synchronous clear on its rst).
- Accepts a stream of operand pairs over valid/ready and drives the MAC's a, b and clear inputs.
- Tracks the end of each vector, waits out the MAC register latency, then captures the dot-product into an output register with its own valid/ready handshake.
- Clears the accumulator for the next vector.

Parameters:
- WIDTH, 8, operand width in bits; must match the MAC's WIDTH.
- CNT_W, 8, width of the pair counter and out_count.
- MAX_LEN, 255, maximum pairs per vector; a vector is force-terminated when it reaches this count; 1 <= MAX_LEN <= 2^CNT_W-1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  sequencer accepts a pair this cycle.
- in_a  input  WIDTH  signed operand a.
- in_b  input  WIDTH  signed operand b.
- in_last  input  1  pair is the last of its vector.
- mac_clr  output  1  to MAC rst; clears the accumulator at the next edge.
- mac_a  output  WIDTH  to MAC a (registered).
- mac_b  output  WIDTH  to MAC b (registered).
- mac_result  input  2*WIDTH  from MAC result.
- out_valid  output  1  dot-product available.
- out_ready  input  1  consumer accepts the dot-product.
- out_data  output  2*WIDTH  captured dot-product (two's complement, wraps).
- out_count  output  CNT_W  number of pairs in the captured vector.
- out_trunc  output  1  only with MACSEQ_TRUNC_FLAG_EN; vector was force-terminated.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state = ACCUM, count = 0.
  - mac_a = mac_b = 0.
  - out_valid = 0, out_data = 0, out_count = 0, out_trunc = 0.
- Combinational outputs:
  - mac_clr = rst OR (state == CAPTURE AND capture fires). The MAC therefore clears in the same edge as sequencer reset.
  - in_ready = (state == ACCUM) AND NOT rst.
- fire_in = in_valid AND in_ready.
- mac_a/mac_b registers:
  - Every cycle they load in_a/in_b when fire_in, else 0.
  - Idle cycles feed 0*0, so the MAC accumulator holds its value (the MAC has no enable).
- count increments on each fire_in.
- Vector end (end_vec) occurs on fire_in with in_last = 1, or on fire_in when count+1 == MAX_LEN (forced termination; in_last ignored beyond that point).
- On end_vec, latch the pair count (count+1) and trunc = NOT in_last, reset count to 0, and go to DRAIN.
- DRAIN (1 cycle): the last pair sits on mac_a/mac_b; the MAC adds it at the end of this cycle. in_ready = 0. Next state is CAPTURE.
- CAPTURE:
  - mac_result is final. Capture fires when (NOT out_valid OR out_ready).
  - On fire:
    - out_data <= mac_result, out_count <= latched count, out_trunc <= latched trunc, out_valid <= 1.
    - mac_clr = 1, so the MAC result becomes 0 at the same edge.
    - Next state is ACCUM.
  - If the output register is still occupied, stay in CAPTURE. The accumulator holds because the inputs are 0 and clear is not asserted. in_ready = 0.
- Output handshake:
  - out_valid clears on out_valid AND out_ready unless a capture fires in the same cycle; in that case it stays 1 with the new data.
  - out_data and out_count are stable while out_valid=1 AND out_ready=0.
- Latency: last pair accepted at cycle t -> out_valid = 1 at cycle t+3 (when the output is free). The next vector's first pair can be accepted at cycle t+3.
- Arithmetic: all values are two's complement. out_data is mac_result verbatim; overflow wraps modulo 2^(2*WIDTH) and is not detected.
- Reset mid-vector: partial sum discarded, the MAC is cleared via mac_clr, any pending out_valid is dropped, and count returns to 0.

Optional Feature:
- Macro: MACSEQ_TRUNC_FLAG_EN.
- Defined: out_trunc port exists, reset 0. It is 1 with the captured result when the vector ended by reaching MAX_LEN without in_last on that pair.
- Undefined: out_trunc port absent. Forced termination still occurs and is otherwise identical.

Test Plan:
- Two-pair vector: (3,4), then (-2,5, last) on consecutive cycles with out_ready=1 -> out_data = 0x0002, out_count = 2, out_valid rises 3 cycles after the last pair.
- Extreme single pair: (-128,-128, last) with WIDTH=8 -> out_data = 0x4000, out_count = 1. The next vector (1,1, last) -> out_data = 0x0001, proving the accumulator was cleared.
- Back-pressure: out_ready=0; vector A=(2,3,last) is captured (6). Vector B=(5,5,last) is accepted, then stalls in CAPTURE with in_ready=0. When out_ready goes high -> 6 is consumed, then 25 follows with out_valid held continuously. No data loss.
- Forced end: MAX_LEN=4, five pairs (1,1) with no in_last -> first result out_data = 4, out_count = 4, out_trunc = 1 (macro on). The fifth pair starts a new vector.
- Gaps: pairs (7,2) and (1,-1, last) separated by 3 cycles of in_valid=0 -> out_data = 13. Idle cycles add nothing.
- Reset mid-vector: two pairs (10,10) accepted, rst for 1 cycle -> out_valid = 0 and mac_clr = 1 during reset. Then (1,2, last) -> out_data = 2, out_count = 1.
